// File: rtl/sdram_host_bridge32.sv
// rtl/sdram_host_bridge32.sv - splits 32-bit host accesses into two 16-bit SDRAM controller requests
module sdram_host_bridge32 #(
   parameter int AW = 24,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-2:0] host_addr,
   input  logic [31:0]   host_wdata,
   input  logic [3:0]    host_be,
   output logic          host_ready,
   output logic          host_rvalid,
   output logic [31:0]   host_rdata,
   output logic          bus_read,
   output logic          bus_write,
   output logic [AW-1:0] bus_addr,
   output logic          bus_burst,
   output logic [2:0]    bus_burst_len,
   output logic [DW-1:0] bus_wdata,
   output logic [1:0]    bus_byteenable,
   input  logic          bus_ready,
   input  logic          bus_rvalid,
   input  logic [DW-1:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, LO, HI, RWAIT} state_t;

   state_t        state, state_nxt;
   logic          we_q;
   logic [AW-2:0] addr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    be_q;
   logic [1:0]    rcnt;
   logic [DW-1:0] rlo_q;
   logic          accept, rv_take, rv_last;

   assign host_ready    = (state == IDLE);
   assign accept        = host_req && host_ready;
   // Returns can land while HI is still stalled, so count in every busy read state.
   assign rv_take       = bus_rvalid && (state != IDLE) && !we_q;
   assign rv_last       = rv_take && (rcnt == 2'd1);
   assign bus_burst     = 1'b0;
   assign bus_burst_len = 3'b000;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Bus outputs are decoded from state and captured request, so they hold while stalled.
   always_comb begin
      state_nxt      = state;
      bus_read       = 1'b0;
      bus_write      = 1'b0;
      bus_addr       = '0;
      bus_wdata      = '0;
      bus_byteenable = 2'b00;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!host_we || (host_be[1:0] != 2'b00)) state_nxt = LO;
               else if (host_be[3:2] != 2'b00)          state_nxt = HI;
            end
         end
         LO: begin
            bus_read       = !we_q;
            bus_write      = we_q;
            bus_addr       = {addr_q, 1'b0};
            bus_wdata      = wdata_q[15:0];
            bus_byteenable = we_q ? be_q[1:0] : 2'b11;
            if (bus_ready) begin
               if (we_q && (be_q[3:2] == 2'b00)) state_nxt = IDLE;
               else                             state_nxt = HI;
            end
         end
         HI: begin
            bus_read       = !we_q;
            bus_write      = we_q;
            bus_addr       = {addr_q, 1'b1};
            bus_wdata      = wdata_q[31:16];
            bus_byteenable = we_q ? be_q[3:2] : 2'b11;
            if (bus_ready) state_nxt = we_q ? IDLE : RWAIT;
         end
         RWAIT: begin
            if (rv_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Low half is staged so host_rdata only changes when a full read completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         rcnt        <= '0;
         rlo_q       <= '0;
         host_rdata  <= '0;
         host_rvalid <= 1'b0;
      end else begin
         host_rvalid <= rv_last;
         if (accept) begin
            we_q    <= host_we;
            addr_q  <= host_addr;
            wdata_q <= host_wdata;
            be_q    <= host_be;
         end
         if (rv_last) begin
            rcnt       <= '0;
            host_rdata <= {bus_rdata, rlo_q};
         end else if (rv_take) begin
            rcnt  <= rcnt + 2'd1;
            rlo_q <= bus_rdata;
         end
      end
   end

endmodule

// File: tb/tb_sdram_host_bridge32.sv
// tb/tb_sdram_host_bridge32.sv - directed self-checking bench for sdram_host_bridge32
module tb_sdram_host_bridge32;

   logic        clk, rst_n;
   logic        host_req, host_we;
   logic [22:0] host_addr;
   logic [31:0] host_wdata;
   logic [3:0]  host_be;
   logic        host_ready, host_rvalid;
   logic [31:0] host_rdata;
   logic        bus_read, bus_write, bus_burst;
   logic [23:0] bus_addr;
   logic [2:0]  bus_burst_len;
   logic [15:0] bus_wdata;
   logic [1:0]  bus_byteenable;
   logic        bus_ready, bus_rvalid;
   logic [15:0] bus_rdata;

   int checks = 0;
   int failures = 0;
   int rv_cnt = 0;
   logic [31:0] rv_data = '0;
   logic [42:0] log_q[$];

   sdram_host_bridge32 dut (
      .clk(clk), .rst_n(rst_n),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_be(host_be), .host_ready(host_ready),
      .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
      .bus_burst(bus_burst), .bus_burst_len(bus_burst_len),
      .bus_wdata(bus_wdata), .bus_byteenable(bus_byteenable),
      .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Entry: {is_write, addr, write data (0 for reads), byteenable}
   always @(posedge clk)
      if (rst_n && (bus_read || bus_write) && bus_ready)
         log_q.push_back({bus_write, bus_addr, bus_write ? bus_wdata : 16'h0, bus_byteenable});

   always @(negedge clk)
      if (host_rvalid) begin
         rv_cnt  = rv_cnt + 1;
         rv_data = host_rdata;
      end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_cmd(input logic we, input logic [22:0] a, input logic [31:0] d, input logic [3:0] be);
      host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; host_be = be;
      tick();
      host_req = 1'b0;
   endtask

   task automatic send_return(input logic [15:0] d);
      bus_rvalid = 1'b1; bus_rdata = d;
      tick();
      bus_rvalid = 1'b0; bus_rdata = 16'h0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_be = '0;
      bus_ready = 1'b1; bus_rvalid = 1'b0; bus_rdata = '0;
      #12;
      checks++;
      if ({bus_read, bus_write, host_rvalid, bus_addr, bus_wdata, bus_byteenable} !== 45'h0) begin
         failures++; $display("FAIL reset_bus: got rd=%b wr=%b rv=%b addr=%h wd=%h be=%b want zeros",
            bus_read, bus_write, host_rvalid, bus_addr, bus_wdata, bus_byteenable);
      end
      checks++;
      if (host_rdata !== 32'h0 || bus_burst !== 1'b0 || bus_burst_len !== 3'b0) begin
         failures++; $display("FAIL reset_rdata: got %h/%b/%h want 0", host_rdata, bus_burst, bus_burst_len);
      end
      @(negedge clk); rst_n = 1'b1;
      tick();
      checks++;
      if (host_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", host_ready); end
   endtask

   task automatic test_write_full();
      log_q.delete();
      host_cmd(1'b1, 23'h000010, 32'hCAFEBEEF, 4'b1111);
      checks++;
      if (host_ready !== 1'b0) begin failures++; $display("FAIL wr_full_busy: got %b want 0", host_ready); end
      tick(); tick();
      checks++;
      if (host_ready !== 1'b1) begin failures++; $display("FAIL wr_full_idle: got %b want 1", host_ready); end
      checks++;
      if (log_q.size() != 2) begin
         failures++; $display("FAIL wr_full_count: got %0d want 2", log_q.size());
      end else if (log_q[0] !== {1'b1, 24'h000020, 16'hBEEF, 2'b11} || log_q[1] !== {1'b1, 24'h000021, 16'hCAFE, 2'b11}) begin
         failures++; $display("FAIL wr_full_data: got %h %h want %h %h", log_q[0], log_q[1],
            {1'b1, 24'h000020, 16'hBEEF, 2'b11}, {1'b1, 24'h000021, 16'hCAFE, 2'b11});
      end
   endtask

   task automatic test_write_partial();
      log_q.delete();
      host_cmd(1'b1, 23'h000055, 32'hA5A51234, 4'b1100);
      tick();
      checks++;
      if (host_ready !== 1'b1 || log_q.size() != 1) begin
         failures++; $display("FAIL wr_hi_only_count: got ready=%b n=%0d want 1/1", host_ready, log_q.size());
      end else if (log_q[0] !== {1'b1, 24'h0000AB, 16'hA5A5, 2'b11}) begin
         failures++; $display("FAIL wr_hi_only_data: got %h want %h", log_q[0], {1'b1, 24'h0000AB, 16'hA5A5, 2'b11});
      end
      log_q.delete();
      host_cmd(1'b1, 23'h0000AA, 32'h11225678, 4'b0110);
      tick(); tick();
      checks++;
      if (log_q.size() != 2) begin
         failures++; $display("FAIL wr_mixed_count: got %0d want 2", log_q.size());
      end else if (log_q[0] !== {1'b1, 24'h000154, 16'h5678, 2'b10} || log_q[1] !== {1'b1, 24'h000155, 16'h1122, 2'b01}) begin
         failures++; $display("FAIL wr_mixed_data: got %h %h", log_q[0], log_q[1]);
      end
   endtask

   task automatic test_write_noop();
      log_q.delete();
      host_cmd(1'b1, 23'h000033, 32'hFFFFFFFF, 4'b0000);
      checks++;
      if (host_ready !== 1'b1) begin failures++; $display("FAIL wr_noop_ready: got %b want 1", host_ready); end
      tick(); tick();
      checks++;
      if (log_q.size() != 0) begin failures++; $display("FAIL wr_noop_bus: got %0d requests want 0", log_q.size()); end
   endtask

   task automatic test_read();
      int rv0;
      log_q.delete();
      rv0 = rv_cnt;
      host_cmd(1'b0, 23'h000003, 32'h0, 4'h0);
      tick(); tick();
      send_return(16'h1234);
      send_return(16'h5678);
      tick(); tick();
      checks++;
      if (log_q.size() != 2) begin
         failures++; $display("FAIL rd_issue_count: got %0d want 2", log_q.size());
      end else if (log_q[0] !== {1'b0, 24'h000006, 16'h0, 2'b11} || log_q[1] !== {1'b0, 24'h000007, 16'h0, 2'b11}) begin
         failures++; $display("FAIL rd_issue_addr: got %h %h", log_q[0], log_q[1]);
      end
      checks++;
      if (rv_cnt - rv0 != 1 || rv_data !== 32'h56781234) begin
         failures++; $display("FAIL rd_result: got pulses=%0d data=%h want 1/56781234", rv_cnt - rv0, rv_data);
      end
      checks++;
      if (host_rdata !== 32'h56781234 || host_ready !== 1'b1) begin
         failures++; $display("FAIL rd_hold: got %h ready=%b want 56781234/1", host_rdata, host_ready);
      end
   endtask

   task automatic test_stall();
      int bad = 0;
      int rv0;
      log_q.delete();
      rv0 = rv_cnt;
      bus_ready = 1'b0;
      host_cmd(1'b0, 23'h0ABCDE, 32'h0, 4'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus_read !== 1'b1 || bus_write !== 1'b0 || bus_addr !== 24'h1579BC || bus_byteenable !== 2'b11) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL stall_stable: got %0d unstable cycles want 0", bad); end
      bus_ready = 1'b1;
      tick();
      checks++;
      if (bus_read !== 1'b1 || bus_addr !== 24'h1579BD || log_q.size() != 1) begin
         failures++; $display("FAIL stall_to_hi: got rd=%b addr=%h n=%0d want 1/1579BD/1", bus_read, bus_addr, log_q.size());
      end
      tick();
      send_return(16'hAAAA);
      send_return(16'h5555);
      tick();
      checks++;
      if (rv_cnt - rv0 != 1 || rv_data !== 32'h5555AAAA) begin
         failures++; $display("FAIL stall_result: got pulses=%0d data=%h want 1/5555AAAA", rv_cnt - rv0, rv_data);
      end
   endtask

   task automatic test_early_return();
      int rv0;
      rv0 = rv_cnt;
      bus_ready = 1'b1;
      host_cmd(1'b0, 23'h000100, 32'h0, 4'h0);
      tick();
      bus_ready = 1'b0;
      send_return(16'hBEEF);
      tick();
      checks++;
      if (bus_read !== 1'b1 || bus_addr !== 24'h000201 || rv_cnt != rv0) begin
         failures++; $display("FAIL early_hi_hold: got rd=%b addr=%h pulses=%0d want 1/000201/0", bus_read, bus_addr, rv_cnt - rv0);
      end
      bus_ready = 1'b1;
      tick();
      send_return(16'hDEAD);
      tick();
      checks++;
      if (rv_cnt - rv0 != 1 || host_rdata !== 32'hDEADBEEF) begin
         failures++; $display("FAIL early_result: got pulses=%0d data=%h want 1/DEADBEEF", rv_cnt - rv0, host_rdata);
      end
   endtask

   task automatic test_reset_mid();
      int rv0;
      rv0 = rv_cnt;
      host_cmd(1'b0, 23'h000007, 32'h0, 4'h0);
      tick(); tick();
      send_return(16'h9999);
      rst_n = 1'b0;
      #1;
      checks++;
      if (host_rdata !== 32'h0 || bus_read !== 1'b0 || host_rvalid !== 1'b0 || host_ready !== 1'b1) begin
         failures++; $display("FAIL midrst_outputs: got rdata=%h rd=%b rv=%b ready=%b want 0/0/0/1",
            host_rdata, bus_read, host_rvalid, host_ready);
      end
      @(negedge clk); rst_n = 1'b1;
      tick();
      send_return(16'h7777);
      tick(); tick();
      checks++;
      if (rv_cnt != rv0 || host_ready !== 1'b1) begin
         failures++; $display("FAIL midrst_spurious: got pulses=%0d ready=%b want 0/1", rv_cnt - rv0, host_ready);
      end
   endtask

   task automatic test_back_to_back();
      int rv0;
      rv0 = rv_cnt;
      host_cmd(1'b0, 23'h000020, 32'h0, 4'h0);
      tick(); tick();
      send_return(16'h1111);
      checks++;
      if (rv_cnt != rv0) begin failures++; $display("FAIL b2b_early_done: got pulses=%0d want 0", rv_cnt - rv0); end
      send_return(16'h2222);
      checks++;
      if (host_rvalid !== 1'b1 || host_ready !== 1'b1) begin
         failures++; $display("FAIL b2b_pulse: got rv=%b ready=%b want 1/1", host_rvalid, host_ready);
      end
      host_cmd(1'b1, 23'h000040, 32'h0000ABCD, 4'b0011);
      tick();
      checks++;
      if (rv_cnt - rv0 != 1 || rv_data !== 32'h22221111 || host_rdata !== 32'h22221111) begin
         failures++; $display("FAIL b2b_result: got pulses=%0d data=%h hold=%h want 1/22221111", rv_cnt - rv0, rv_data, host_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_write_full();
      test_write_partial();
      test_write_noop();
      test_read();
      test_stall();
      test_early_return();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdram_host_bridge32.md
SDRAM_HOST_BRIDGE32 -- requirements
Module: sdram_host_bridge32

Interface
REQ-001 SHALL have parameter AW, default 24: SDRAM controller half-word address width.
REQ-002 SHALL have parameter DW, default 16: SDRAM controller data width, fixed at 16.
REQ-003 SHALL have port clk, input, 1: the block's single clock.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port host_req, input, 1: host request valid.
REQ-006 SHALL have port host_we, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port host_addr, input, AW-1: 32-bit word address.
REQ-008 SHALL have port host_wdata, input, 32: write data.
REQ-009 SHALL have port host_be, input, 4: byte enables, where bit0 = byte [7:0].
REQ-010 SHALL have port host_ready, output, 1: request accepted when host_req && host_ready.
REQ-011 SHALL have port host_rvalid, output, 1: one-cycle read-data pulse.
REQ-012 SHALL have port host_rdata, output, 32: read data.
REQ-013 SHALL have ports bus_read and bus_write, outputs, 1 each: request strobes to the SDRAM controller.
REQ-014 SHALL have port bus_addr, output, AW: half-word address.
REQ-015 SHALL have port bus_burst, output, 1, tied to 0.
REQ-016 SHALL have port bus_burst_len, output, 3, tied to 0.
REQ-017 SHALL have port bus_wdata, output, 16: write data half-word.
REQ-018 SHALL have port bus_byteenable, output, 2: byte enables for the half-word.
REQ-019 SHALL have port bus_ready, input, 1: the controller accepts the request in any cycle where (bus_read||bus_write) && bus_ready.
REQ-020 SHALL have ports bus_rvalid, input, 1, and bus_rdata, input, 16: read returns, arriving in issue order.

Function
REQ-021 SHALL implement FSM states IDLE, LO, HI and RWAIT.
REQ-022 SHALL drive host_ready = 1 only in IDLE, and SHALL register host_we, host_addr, host_wdata and host_be on accept.
REQ-023 Read accept SHALL transition IDLE->LO; LO SHALL issue bus_read with bus_addr = {addr,1'b0} and bus_byteenable = 2'b11.
REQ-024 On LO read acceptance (bus_read && bus_ready), the FSM SHALL go to HI; HI SHALL issue bus_read with bus_addr = {addr,1'b1}.
REQ-025 On HI read acceptance, the FSM SHALL go to RWAIT.
REQ-026 Write accept SHALL go to LO if be[1:0]!=0, else to HI if be[3:2]!=0, else stay in IDLE with no bus activity (be=0000 is a completed no-op).
REQ-027 Write LO SHALL drive bus_write, bus_addr = {addr,0}, bus_wdata = wdata[15:0] and bus_byteenable = be[1:0].
REQ-028 On LO write acceptance, the FSM SHALL go to HI if be[3:2]!=0, else to IDLE.
REQ-029 Write HI SHALL drive bus_write, bus_addr = {addr,1}, bus_wdata = wdata[31:16] and bus_byteenable = be[3:2]; on acceptance the FSM SHALL go to IDLE.
REQ-030 bus_read, bus_write, bus_addr, bus_wdata and bus_byteenable SHALL remain stable while a request is pending and bus_ready=0.
REQ-031 A 2-bit return counter SHALL count bus_rvalid in every state, including HI, because data may return before the HI request is accepted.
REQ-032 The first bus_rvalid SHALL latch host_rdata[15:0]; the second SHALL latch host_rdata[31:16].
REQ-033 On the cycle after the second bus_rvalid, the block SHALL pulse host_rvalid=1 for exactly one cycle, return the FSM to IDLE and clear the counter.
REQ-034 host_ready MAY be 1 in the same cycle as host_rvalid.
REQ-035 bus_rvalid received in IDLE (no read outstanding) SHALL be ignored.
REQ-036 host_rdata SHALL hold its value until the next read completes.
REQ-037 The block SHALL have at most one host transaction outstanding.
REQ-038 Minimum write latency SHALL be 2 bus requests accepted in consecutive cycles when bus_ready=1 (accept -> LO -> HI -> IDLE).
REQ-039 Minimum read latency SHALL be accept + 2 issue cycles + controller latency + 1 cycle.

Reset
REQ-040 On rst_n=0, the block SHALL asynchronously set state = IDLE, counter = 0, bus_read = bus_write = 0, host_rvalid = 0, host_rdata = 0, bus_addr = 0, bus_wdata = 0 and bus_byteenable = 0.
REQ-041 Reset mid-transaction SHALL abandon the transaction, with no host_rvalid after reset release.
REQ-042 host_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-043 Write addr=0x000010, wdata=0xCAFEBEEF, be=1111, bus_ready=1 -> bus_write at 0x000020 with 0xBEEF/11, then at 0x000021 with 0xCAFE/11; IDLE after 3 cycles.
REQ-044 Write be=1100 -> a single bus_write at {addr,1}, data wdata[31:16], byteenable 11; no LO access.
REQ-045 Write be=0000 -> no bus activity; host_ready stays 1.
REQ-046 Read addr=0x000003 with bus_rvalid returning 0x1234 then 0x5678 -> bus_read at 0x000006 then 0x000007; one host_rvalid with host_rdata=0x56781234.
REQ-047 bus_ready held 0 for 5 cycles during LO -> request and address stable throughout; proceeds to HI on the first bus_ready=1.
REQ-048 First bus_rvalid arriving while in HI with bus_ready=0 -> still counted; host_rdata correct after the second bus_rvalid.
REQ-049 rst_n asserted in RWAIT after one bus_rvalid -> all outputs reset, host_ready=1 after release, and no spurious host_rvalid.
